// File: rtl/pc_update_unit.sv
// Program counter and next-PC select for the single-issue MIPS core.
// Ports: clk/rst_n; stall; branch/jump/jr requests -> pc, pc_plus4,
// fetch_valid, flush (one-cycle squash), addr_err/bad_addr (jr trap).
module pc_update_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc_plus4,
    input  logic [31:0] branch_offset_sl2,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        flush,
    output logic        addr_err,
    output logic [31:0] bad_addr
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] bad_q, bad_d;
    logic        fv_q, fv_d;
    logic        fl_q, fl_d;
    logic        err_q, err_d;

    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;
    logic        jr_mis;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_tgt   = branch_pc_plus4 + branch_offset_sl2;
    assign jmp_tgt  = {branch_pc_plus4[31:28], jump_index, 2'b00};
    assign jr_mis   = |jr_target[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            fv_q    <= 1'b0;
            fl_q    <= 1'b0;
            err_q   <= 1'b0;
            bad_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fv_q    <= fv_d;
            fl_q    <= fl_d;
            err_q   <= err_d;
            bad_q   <= bad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fv_d    = fv_q;
        fl_d    = 1'b0;
        err_d   = err_q;
        bad_d   = bad_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                fv_d    = 1'b1;
            end
            RUN: begin
                if (!stall) begin
                    if (jr) begin
                        fl_d    = 1'b1;
                        state_d = FLUSH;
                        if (jr_mis) begin
                            pc_d  = TRAP_PC;
                            err_d = 1'b1;
                            // keep the first offending address
                            if (!err_q) begin
                                bad_d = jr_target;
                            end
                        end else begin
                            pc_d = jr_target;
                        end
                    end else if (jump) begin
                        pc_d    = jmp_tgt;
                        fl_d    = 1'b1;
                        state_d = FLUSH;
                    end else if (branch_taken) begin
                        pc_d    = br_tgt;
                        fl_d    = 1'b1;
                        state_d = FLUSH;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            FLUSH: begin
                // requests here come from the squashed slot
                if (!stall) begin
                    pc_d    = pc_plus4;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign pc          = pc_q;
    assign fetch_valid = fv_q;
    assign flush       = fl_q;
    assign addr_err    = err_q;
    assign bad_addr    = bad_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit.
// Scoreboard of expected pc/flush/trap state per clock.
module tb_pc_update_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_pc_plus4;
    logic [31:0] branch_offset_sl2;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush;
    logic        addr_err;
    logic [31:0] bad_addr;

    typedef struct {
        logic [31:0] pc;
        logic        fl;
        logic        fv;
        logic        err;
        logic [31:0] bad;
    } exp_t;

    typedef struct {
        logic        st;
        logic        br;
        logic        jp;
        logic        jr;
        logic [31:0] pp4;
        logic [31:0] off;
        logic [31:0] jrt;
        logic [25:0] idx;
        exp_t        e;
    } stp_t;

    exp_t sbq[$];
    stp_t stq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    pc_update_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_pc_plus4   (branch_pc_plus4),
        .branch_offset_sl2 (branch_offset_sl2),
        .jump              (jump),
        .jump_index        (jump_index),
        .jr                (jr),
        .jr_target         (jr_target),
        .pc                (pc),
        .pc_plus4          (pc_plus4),
        .fetch_valid       (fetch_valid),
        .flush             (flush),
        .addr_err          (addr_err),
        .bad_addr          (bad_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic add(
        input logic st, br, jp, j,
        input logic [31:0] pp4, off, jrt,
        input logic [25:0] idx,
        input logic [31:0] epc,
        input logic efl, eerr,
        input logic [31:0] ebad
    );
        stp_t s;
        s.st = st; s.br = br; s.jp = jp; s.jr = j;
        s.pp4 = pp4; s.off = off; s.jrt = jrt; s.idx = idx;
        s.e.pc = epc; s.e.fl = efl; s.e.fv = 1'b1;
        s.e.err = eerr; s.e.bad = ebad;
        stq.push_back(s);
    endtask

    task automatic drive(input stp_t s);
        stall = s.st; branch_taken = s.br;
        jump = s.jp; jr = s.jr;
        branch_pc_plus4 = s.pp4;
        branch_offset_sl2 = s.off;
        jr_target = s.jrt; jump_index = s.idx;
    endtask

    task automatic clear_in();
        stall = 0; branch_taken = 0; jump = 0; jr = 0;
        branch_pc_plus4 = 0; branch_offset_sl2 = 0;
        jr_target = 0; jump_index = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        clear_in();
        rst_n = 1'b0;
        #12;
        n_chk++;
        if (pc !== 32'h0 || flush !== 1'b0 || fetch_valid !== 1'b0 ||
            addr_err !== 1'b0 || bad_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: got pc=%h fl=%b fv=%b err=%b bad=%h",
                     pc, flush, fetch_valid, addr_err, bad_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_chk++;
        if (pc !== 32'h0 || fetch_valid !== 1'b0 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL boot: got pc=%h fv=%b fl=%b want 0 0 0",
                     pc, fetch_valid, flush);
        end
        add(0,0,0,0, 0,0,0,0, 32'h0, 0, 0, 0);
        add(0,0,0,0, 0,0,0,0, 32'h4, 0, 0, 0);
        add(0,0,0,0, 0,0,0,0, 32'h8, 0, 0, 0);
        foreach (stq[i]) begin
            drive(stq[i]);
            sbq.push_back(stq[i].e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_chk++;
            if (pc !== e.pc || flush !== e.fl || fetch_valid !== e.fv ||
                addr_err !== e.err || bad_addr !== e.bad) begin
                n_fail++;
                $display("FAIL seq[%0d]: got pc=%h fl=%b fv=%b want pc=%h fl=%b fv=%b",
                         i, pc, flush, fetch_valid, e.pc, e.fl, e.fv);
            end
        end
        stq.delete();
    endtask

    task automatic test_branch();
        exp_t e;
        add(0,1,0,0, 32'h100, 32'hFFFF_FFF0, 0,0, 32'h0F0, 1, 0, 0);
        add(0,0,0,0, 0,0,0,0, 32'h0F4, 0, 0, 0);
        add(0,0,0,0, 0,0,0,0, 32'h0F8, 0, 0, 0);
        add(0,1,0,0, 32'hFFFF_FFFC, 32'h8, 0,0, 32'h4, 1, 0, 0);
        add(0,0,0,0, 0,0,0,0, 32'h8, 0, 0, 0);
        foreach (stq[i]) begin
            drive(stq[i]);
            sbq.push_back(stq[i].e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_chk++;
            if (pc !== e.pc || flush !== e.fl || fetch_valid !== e.fv ||
                addr_err !== e.err || bad_addr !== e.bad) begin
                n_fail++;
                $display("FAIL branch[%0d]: got pc=%h fl=%b want pc=%h fl=%b",
                         i, pc, flush, e.pc, e.fl);
            end
        end
        stq.delete();
    endtask

    task automatic test_priority();
        exp_t e;
        add(0,1,1,1, 32'h100, 32'hFFFF_FFF0, 32'h2000, 26'h40,
            32'h2000, 1, 0, 0);
        add(0,1,1,1, 32'h100, 32'hFFFF_FFF0, 32'h2000, 26'h40,
            32'h2004, 0, 0, 0);
        add(0,1,1,0, 32'h3000_0100, 32'hFFFF_FFF0, 0, 26'h40,
            32'h3000_0100, 1, 0, 0);
        add(0,1,0,0, 32'h3000_0100, 32'hFFFF_FFF0, 0, 0,
            32'h3000_0104, 0, 0, 0);
        add(0,1,0,0, 32'h3000_0100, 32'hFFFF_FFF0, 0, 0,
            32'h3000_00F0, 1, 0, 0);
        add(0,0,0,0, 0,0,0,0, 32'h3000_00F4, 0, 0, 0);
        foreach (stq[i]) begin
            drive(stq[i]);
            sbq.push_back(stq[i].e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_chk++;
            if (pc !== e.pc || flush !== e.fl || fetch_valid !== e.fv ||
                addr_err !== e.err || bad_addr !== e.bad) begin
                n_fail++;
                $display("FAIL prio[%0d]: got pc=%h fl=%b want pc=%h fl=%b",
                         i, pc, flush, e.pc, e.fl);
            end
        end
        stq.delete();
    endtask

    task automatic test_stall();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            add(1,1,0,0, 32'h400, 32'h10, 0,0, 32'h3000_00F4, 0, 0, 0);
        end
        add(0,1,0,0, 32'h400, 32'h10, 0,0, 32'h410, 1, 0, 0);
        add(0,0,0,0, 0,0,0,0, 32'h414, 0, 0, 0);
        foreach (stq[i]) begin
            drive(stq[i]);
            sbq.push_back(stq[i].e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_chk++;
            if (pc !== e.pc || flush !== e.fl || fetch_valid !== e.fv ||
                addr_err !== e.err || bad_addr !== e.bad) begin
                n_fail++;
                $display("FAIL stall[%0d]: got pc=%h fl=%b want pc=%h fl=%b",
                         i, pc, flush, e.pc, e.fl);
            end
        end
        stq.delete();
    endtask

    task automatic test_wrap();
        exp_t e;
        add(0,0,0,1, 0,0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0, 0);
        add(0,0,0,0, 0,0,0,0, 32'h0, 0, 0, 0);
        add(0,0,0,0, 0,0,0,0, 32'h4, 0, 0, 0);
        foreach (stq[i]) begin
            drive(stq[i]);
            sbq.push_back(stq[i].e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_chk++;
            if (pc !== e.pc || flush !== e.fl || fetch_valid !== e.fv ||
                addr_err !== e.err || bad_addr !== e.bad ||
                pc_plus4 !== e.pc + 32'd4) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got pc=%h p4=%h fl=%b want pc=%h fl=%b",
                         i, pc, pc_plus4, flush, e.pc, e.fl);
            end
        end
        stq.delete();
    endtask

    task automatic test_misalign();
        exp_t e;
        add(0,0,0,1, 0,0, 32'h1002, 0, 32'h180, 1, 1, 32'h1002);
        add(0,0,0,0, 0,0,0,0, 32'h184, 0, 1, 32'h1002);
        add(0,0,0,1, 0,0, 32'h3, 0, 32'h180, 1, 1, 32'h1002);
        add(0,0,0,0, 0,0,0,0, 32'h184, 0, 1, 32'h1002);
        foreach (stq[i]) begin
            drive(stq[i]);
            sbq.push_back(stq[i].e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_chk++;
            if (pc !== e.pc || flush !== e.fl || fetch_valid !== e.fv ||
                addr_err !== e.err || bad_addr !== e.bad) begin
                n_fail++;
                $display("FAIL trap[%0d]: got pc=%h fl=%b err=%b bad=%h want pc=%h fl=%b err=%b bad=%h",
                         i, pc, flush, addr_err, bad_addr,
                         e.pc, e.fl, e.err, e.bad);
            end
        end
        stq.delete();
    endtask

    task automatic test_mid_reset();
        exp_t e;
        add(0,0,0,1, 0,0, 32'h5000, 0, 32'h5000, 1, 1, 32'h1002);
        foreach (stq[i]) begin
            drive(stq[i]);
            sbq.push_back(stq[i].e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_chk++;
            if (pc !== e.pc || flush !== e.fl || fetch_valid !== e.fv ||
                addr_err !== e.err || bad_addr !== e.bad) begin
                n_fail++;
                $display("FAIL prerst[%0d]: got pc=%h fl=%b want pc=%h fl=%b",
                         i, pc, flush, e.pc, e.fl);
            end
        end
        stq.delete();
        #2;
        clear_in();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (pc !== 32'h0 || flush !== 1'b0 || addr_err !== 1'b0 ||
            bad_addr !== 32'h0 || fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst: got pc=%h fl=%b err=%b bad=%h fv=%b",
                     pc, flush, addr_err, bad_addr, fetch_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_chk++;
        if (pc !== 32'h0 || fetch_valid !== 1'b0 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL reboot: got pc=%h fv=%b fl=%b want 0 0 0",
                     pc, fetch_valid, flush);
        end
        add(0,0,0,0, 0,0,0,0, 32'h0, 0, 0, 0);
        add(0,0,0,0, 0,0,0,0, 32'h4, 0, 0, 0);
        foreach (stq[i]) begin
            drive(stq[i]);
            sbq.push_back(stq[i].e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_chk++;
            if (pc !== e.pc || flush !== e.fl || fetch_valid !== e.fv ||
                addr_err !== e.err || bad_addr !== e.bad) begin
                n_fail++;
                $display("FAIL restart[%0d]: got pc=%h fl=%b fv=%b want pc=%h fl=%b fv=%b",
                         i, pc, flush, fetch_valid, e.pc, e.fl, e.fv);
            end
        end
        stq.delete();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_priority();
        test_stall();
        test_wrap();
        test_misalign();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
